// File: rtl/tc_clk_pkg.sv
// tc_clk_pkg: shared types and helpers for the tc_clk_* clock cells.
package tc_clk_pkg;

    typedef enum logic [0:0] {IDLE, RUN} clk_div_state_e;

    // Ratios 0 and 1 cannot form a high and a low phase, so they collapse to 2.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'd2) ? 32'd2 : d;
    endfunction

endpackage

// File: rtl/tc_clk_mux2.sv
// tc_clk_mux2: static two-input clock select.
module tc_clk_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);

    assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/tc_clk_int_div.sv
// tc_clk_int_div: run-time programmable integer clock divider with period-aligned
// enable/ratio updates and a DFT bypass.
module tc_clk_int_div
    import tc_clk_pkg::*;
#(
    parameter int unsigned DivWidth   = 8,
    parameter int unsigned DefaultDiv = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                test_mode_i,
    input  logic [DivWidth-1:0] div_i,
    input  logic                div_valid_i,
    output logic                div_ready_o,
    output logic                clk_o
);

    clk_div_state_e      state_q, state_d;
    logic [DivWidth-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [DivWidth-1:0] hi, cnt_inc, div_clamped;
    logic                clk_div_q, clk_div_d, boundary;

    assign hi          = div_q - (div_q >> 1);
    assign cnt_inc     = cnt_q + DivWidth'(1);
    assign div_clamped = DivWidth'(clamp_div(32'(div_i)));
    // Boundary always falls in the low phase, so restarting or stopping here cannot make a runt.
    assign boundary    = (state_q == RUN) && (cnt_q == div_q - DivWidth'(1));
    assign div_ready_o = (state_q == IDLE) || boundary;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clk_div_d = clk_div_q;
        div_d     = (div_valid_i && div_ready_o) ? div_clamped : div_q;
        if (state_q == IDLE) begin
            cnt_d     = '0;
            clk_div_d = en_i;
            state_d   = en_i ? RUN : IDLE;
        end else if (boundary) begin
            cnt_d     = '0;
            clk_div_d = en_i;
            state_d   = en_i ? RUN : IDLE;
        end else begin
            cnt_d     = cnt_inc;
            clk_div_d = (cnt_inc < hi);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= DivWidth'(DefaultDiv);
            clk_div_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            clk_div_q <= clk_div_d;
        end
    end

    tc_clk_mux2 u_mux (
        .clk0_i    (clk_div_q),
        .clk1_i    (clk_i),
        .clk_sel_i (test_mode_i),
        .clk_o     (clk_o)
    );

endmodule

// File: tb/tb_tc_clk_int_div.sv
// tb_tc_clk_int_div: random and directed stimulus against a period-pattern queue model.
module tb_tc_clk_int_div;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       en_i = 1'b0;
    logic       test_mode_i = 1'b0;
    logic       div_valid_i = 1'b0;
    logic [7:0] div_i = 8'd0;
    logic       div_ready_o, clk_o;

    int checks = 0;
    int failures = 0;
    bit q[$];
    int ratio = 2;

    always #5 clk_i = ~clk_i;

    tc_clk_int_div #(.DivWidth(8), .DefaultDiv(2)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .test_mode_i (test_mode_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .clk_o       (clk_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // A period of ratio r is ceil(r/2) high cycles followed by floor(r/2) low cycles.
    task automatic push_period(input int r);
        for (int i = 0; i < r; i++) q.push_back(i < r - r / 2);
    endtask

    task automatic step(input string tag, input logic en, input logic v, input logic [7:0] d);
        en_i = en;
        div_valid_i = v;
        div_i = d;
        @(posedge clk_i);
        if (v && q.size() <= 1) ratio = (d < 2) ? 2 : int'(d);
        if (q.size() > 0) void'(q.pop_front());
        if (q.size() == 0 && en) push_period(ratio);
        @(negedge clk_i);
        check({tag, "_clk"}, 32'(clk_o), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        check({tag, "_rdy"}, 32'(div_ready_o), (q.size() <= 1) ? 32'd1 : 32'd0);
    endtask

    initial begin
        @(negedge clk_i);
        check("rst_clk", 32'(clk_o), 32'd0);
        check("rst_rdy", 32'(div_ready_o), 32'd1);
        rst_ni = 1'b1;
        for (int i = 0; i < 8; i++) step("div2", 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) step("stop", 1'b0, 1'b0, 8'd0);
        step("ld5", 1'b0, 1'b1, 8'd5);
        for (int i = 0; i < 15; i++) step("div5", 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 6; i++) step("ld4", 1'b1, 1'b1, 8'd4);
        for (int i = 0; i < 9; i++) step("div4", 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 2; i++) step("req7", 1'b1, 1'b1, 8'd7);
        for (int i = 0; i < 24; i++) step("div7", 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 8; i++) step("ld6", 1'b1, 1'b1, 8'd6);
        for (int i = 0; i < 7; i++) step("run6", 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++) step("drop6", 1'b0, 1'b0, 8'd0);
        step("idle_ld_en", 1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 8; i++) step("div0", 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) step("ld1", 1'b1, 1'b1, 8'd1);
        for (int i = 0; i < 8; i++) step("div1", 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) step("ld255", 1'b1, 1'b1, 8'd255);
        for (int i = 0; i < 520; i++) step("div255", 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 2500; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 12));
            step("rand", $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, d);
        end
        for (int i = 0; i < 260; i++) step("drain", 1'b0, 1'b0, 8'd0);
        step("ld8", 1'b1, 1'b1, 8'd8);
        step("hi8", 1'b1, 1'b0, 8'd0);
        check("pre_rst_hi", 32'(clk_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_clk", 32'(clk_o), 32'd0);
        check("arst_rdy", 32'(div_ready_o), 32'd1);
        q.delete();
        ratio = 2;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) step("post_rst", 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) step("stop2", 1'b0, 1'b0, 8'd0);
        test_mode_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1 check("tm_hi", 32'(clk_o), 32'd1);
            @(negedge clk_i);
            #1 check("tm_lo", 32'(clk_o), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
